alu_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one ALU datapath among 4 requesters.
- Drives the 2-bit select of the 4:1 operand multiplexer in front of the ALU and issues a start pulse.
- Waits a fixed ALU latency, captures the result and returns it to the winning requester with a one-cycle done pulse.
- Sits between the requester ports and the operand mux/ALU in the ALU subsystem.

---
 rtl/alu_share_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one fixed-latency ALU among four requesters.
// Grants one requester, pulses alu_start, waits LATENCY cycles, then returns the result with a done pulse.
//   state | meaning
//   IDLE  | no operation; sample req and pick the next winner
//   ISSUE | alu_start pulse; latency counter loaded
//   WAIT  | counting down ALU latency
//   DONE  | done pulse to grantee; result captured on exit
module alu_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] alu_result,
  output logic [1:0]       sel,
  output logic [3:0]       grant,
  output logic             alu_start,
  output logic [3:0]       done,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_nx;
  logic [1:0]       last, last_nx;
  logic [1:0]       sel_nx;
  logic [3:0]       grant_nx;
  logic [3:0]       done_nx;
  logic             start_nx;
  logic             busy_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [WIDTH-1:0] result_nx;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;

  // Search starts one past the previous winner so every requester is reached within four operations.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + i[1:0];
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    last_nx   = last;
    sel_nx    = sel;
    grant_nx  = grant;
    done_nx   = '0;
    start_nx  = 1'b0;
    busy_nx   = busy;
    cnt_nx    = cnt;
    result_nx = result;
    case (state)
      IDLE: begin
        if (found) begin
          sel_nx   = win;
          grant_nx = 4'b0001 << win;
          start_nx = 1'b1;
          busy_nx  = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nx = 8'(LATENCY - 1);
        if (LATENCY == 1) begin
          done_nx  = grant;
          state_nx = DONE;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 8'd1;
        if (cnt == 8'd1) begin
          done_nx  = grant;
          state_nx = DONE;
        end
      end
      DONE: begin
        result_nx = alu_result;
        last_nx   = sel;
        grant_nx  = '0;
        busy_nx   = 1'b0;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 2'd3;
      sel       <= '0;
      grant     <= '0;
      done      <= '0;
      alu_start <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      result    <= '0;
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      sel       <= sel_nx;
      grant     <= grant_nx;
      done      <= done_nx;
      alu_start <= start_nx;
      busy      <= busy_nx;
      cnt       <= cnt_nx;
      result    <= result_nx;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: three arbiter builds (latency 2, 1, 5) share stimulus; each has its own
// operation-level model predicting winners and completion cycles, and a monitor checking outputs.
module tb_alu_share_arbiter;
  localparam int W = 8;

  typedef struct {
    int w;
    int dcyc;
  } op_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [W-1:0] alu_result = '0;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    #1;
    alu_result = W'($urandom);
  end

  function automatic void check(input string name, input int lat, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lat=%0d cyc=%0d actual=%0h required=%0h", name, lat, cyc, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 5;

    logic [1:0]   sel;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         alu_start;
    logic         busy;
    logic [W-1:0] result;

    alu_share_arbiter #(.WIDTH(W), .LATENCY(L)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .alu_result(alu_result),
      .sel(sel),
      .grant(grant),
      .alu_start(alu_start),
      .done(done),
      .result(result),
      .busy(busy)
    );

    op_t          q[$];
    int           last_w = 3;
    int           free_edge = 0;
    int           cur_issue = -100;
    int           cur_w = 0;
    bit           have_op = 0;
    logic [W-1:0] exp_res = '0;
    bit           res_pending = 0;

    // Model: a request sampled at edge k with the arbiter free gives ISSUE at cycle k,
    // done at k+L, and the arbiter free to sample again at edge k+L+2.
    always @(negedge clk) begin
      int k;
      int w;
      #2;
      if (!rst_n) begin
        q.delete();
        have_op = 0;
        last_w = 3;
        free_edge = cyc + 2;
        exp_res = '0;
        res_pending = 0;
      end else if (cyc + 1 >= free_edge && req != 4'b0) begin
        k = cyc + 1;
        w = -1;
        for (int i = 1; i <= 4; i++)
          if (w < 0 && req[(last_w + i) % 4]) w = (last_w + i) % 4;
        q.push_back('{w, k + L});
        cur_issue = k;
        cur_w = w;
        have_op = 1;
        last_w = w;
        free_edge = k + L + 2;
      end
    end

    always @(negedge clk) begin
      bit         act;
      logic [3:0] oh;
      op_t        op;
      act = have_op && cyc >= cur_issue && cyc <= cur_issue + L;
      oh  = act ? 4'(1 << cur_w) : 4'b0;
      check("grant", L, 32'(grant), 32'(oh));
      check("busy", L, 32'(busy), 32'(act));
      check("alu_start", L, 32'(alu_start), 32'(act && cyc == cur_issue));
      if (act) check("sel", L, 32'(sel), 32'(cur_w));
      if (res_pending) begin
        exp_res = alu_result;
        res_pending = 0;
      end
      check("result", L, 32'(result), 32'(exp_res));
      if (done != 4'b0) begin
        if (q.size() == 0) begin
          check("done_unexpected", L, 32'(done), 32'h0);
        end else begin
          op = q.pop_front();
          check("done_who", L, 32'(done), 32'(1 << op.w));
          check("done_time", L, 32'(cyc), 32'(op.dcyc));
          res_pending = 1;
        end
      end else if (q.size() > 0 && q[0].dcyc <= cyc) begin
        check("done_missing", L, 32'(done), 32'(1 << q[0].w));
        void'(q.pop_front());
      end
    end

    always @(negedge rst_n) begin
      #1;
      check("rst_grant", L, 32'(grant), 32'h0);
      check("rst_sel", L, 32'(sel), 32'h0);
      check("rst_busy", L, 32'(busy), 32'h0);
      check("rst_done", L, 32'(done), 32'h0);
      check("rst_start", L, 32'(alu_start), 32'h0);
      check("rst_result", L, 32'(result), 32'h0);
    end
  end

  task automatic phase(input logic [3:0] r, input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      req = r;
    end
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    phase(4'b0100, 10);
    phase(4'b1111, 48);
    phase(4'b0000, 6);
    phase(4'b1000, 1);
    phase(4'b1001, 24);

    // Reset while the latency-2 build sits in WAIT.
    t = 0;
    while (!(gi[0].have_op && cyc == gi[0].cur_issue + 1) && t < 40) begin
      req = 4'b1111;
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_timeout actual=%0d required<40", t);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    phase(4'b1111, 12);

    repeat (600) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
    end
    phase(4'b0000, 15);

    check("drain_q_lat2", 2, 32'(gi[0].q.size()), 32'h0);
    check("drain_q_lat1", 1, 32'(gi[1].q.size()), 32'h0);
    check("drain_q_lat5", 5, 32'(gi[2].q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
